// File: rtl/mgmt_pkg.sv
// rtl/mgmt_pkg.sv - shared types for management UART transmit arbitration
package mgmt_pkg;

  localparam int MGMT_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    WAIT_NEXT = 2'd2
  } mgmt_txarb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin pick starting after ptr
module rr_priority_select
  import mgmt_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   ptr,
  output logic [2:0]   sel,
  output logic         any
);

  logic [MGMT_MAX_REQ-1:0] req_ext;
  logic [2:0]              idx;

  assign req_ext = MGMT_MAX_REQ'(req);

  // Nearest requester after ptr wins; ptr itself is checked last.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N; k++) begin
      idx = 3'((int'(ptr) + k) % N);
      if (!any && req_ext[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mgmt_uart_tx_arbiter.sv
// rtl/mgmt_uart_tx_arbiter.sv - frame-granular round-robin sharing of the management UART transmitter
module mgmt_uart_tx_arbiter
  import mgmt_pkg::*;
#(
  parameter int          NUM_REQ = 2,
  parameter logic [15:0] TIMEOUT = 16'hffff
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_en,
  input  logic                 uart_tx_done,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  mgmt_txarb_state_t state;
  logic [2:0]  ptr;
  logic [2:0]  sel;
  logic [2:0]  cur;
  logic        any;
  logic        last_q;
  logic        xfer;
  logic        cur_valid;
  logic        cur_last;
  logic [7:0]  cur_data;
  logic [15:0] wdt;
  logic        wdt_expired;

  rr_priority_select #(.N(NUM_REQ)) u_sel (
    .req (req_valid),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  // Arbitration only in IDLE; mid-frame the granted requester stays selected.
  assign cur = (state == IDLE) ? sel : grant_id;

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cur == 3'(i)) begin
        cur_valid    = req_valid[i];
        cur_last     = req_last[i];
        cur_data     = req_data[8*i +: 8];
        req_ready[i] = (state == IDLE && any) || (state == WAIT_NEXT);
      end
    end
  end

  assign xfer        = ((state == IDLE) || (state == WAIT_NEXT)) && cur_valid;
  assign busy        = (state != IDLE);
  assign wdt_expired = (wdt == TIMEOUT - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= 3'(NUM_REQ - 1);
      grant_id     <= '0;
      last_q       <= 1'b0;
      wdt          <= '0;
      uart_tx_data <= '0;
      uart_tx_en   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      uart_tx_en  <= 1'b0;
      timeout_err <= 1'b0;
      if (xfer) begin
        grant_id     <= cur;
        uart_tx_data <= cur_data;
        uart_tx_en   <= 1'b1;
        last_q       <= cur_last;
        wdt          <= '0;
        state        <= WAIT_DONE;
      end else begin
        case (state)
          WAIT_DONE: begin
            // A done arriving on the expiry cycle still completes the byte.
            if (uart_tx_done) begin
              wdt <= '0;
              if (last_q) begin
                ptr   <= grant_id;
                state <= IDLE;
              end else begin
                state <= WAIT_NEXT;
              end
            end else if (wdt_expired) begin
              ptr         <= grant_id;
              state       <= IDLE;
              timeout_err <= 1'b1;
              wdt         <= '0;
            end else begin
              wdt <= wdt + 16'd1;
            end
          end
          WAIT_NEXT: begin
            if (wdt_expired) begin
              ptr         <= grant_id;
              state       <= IDLE;
              timeout_err <= 1'b1;
              wdt         <= '0;
            end else begin
              wdt <= wdt + 16'd1;
            end
          end
          default: wdt <= '0;
        endcase
      end
    end
  end

endmodule
